// File: rtl/plab5_mcore_mem_net_req_adapter_pkg.sv
// Shared plab5 mcore constants: destination-mode encodings, region
// boundary defaults and memory/network message width helpers.
package plab5_mcore_mem_net_req_adapter_pkg;

  typedef enum logic {
    DEST_INTERLEAVE = 1'b0,
    DEST_REGION     = 1'b1
  } dest_mode_e;

  localparam int DEST_MODE_INTERLEAVE = 0;
  localparam int DEST_MODE_REGION     = 1;

  localparam logic [31:0] INST_BOUNDARY_DEFAULT = 32'h4000;
  localparam logic [31:0] DATA_BOUNDARY_DEFAULT = 32'hc000;

  localparam int MEM_TYPE_NBITS = 3;

  // Byte-length field of a memory request.
  function automatic int mem_len_nbits(int d);
    return $clog2(d / 8);
  endfunction

  // {type, opaque, addr, len, data}
  function automatic int mem_req_nbits(int o, int a, int d);
    return MEM_TYPE_NBITS + o + a + mem_len_nbits(d) + d;
  endfunction

  // {dest, src, opaque, payload}
  function automatic int net_msg_nbits(int p, int o, int s);
    return s + s + o + p;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_net_req_adapter_queue.sv
// Circular request buffer with val/rdy on both sides.
// Entries are dropped by clearing pointers on reset.
module plab5_mcore_ReqQueue #(
  parameter int p_depth = 2,
  parameter int p_nbits = 8,
  localparam int aw = $clog2(p_depth),
  localparam int cw = $clog2(p_depth + 1)
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic [cw-1:0]      count
);

  localparam logic [cw-1:0] full_cnt = cw'(p_depth);
  localparam logic [aw-1:0] last_ptr = aw'(p_depth - 1);

  logic [p_nbits-1:0] mem [p_depth];
  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;
  logic               enq_fire;
  logic               deq_fire;

  assign enq_rdy  = (count != full_cnt);
  assign deq_val  = (count != '0);
  assign deq_msg  = mem[rd_ptr];
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[wr_ptr] <= enq_msg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
    end else if (enq_fire) begin
      wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + aw'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
    end else if (deq_fire) begin
      rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + aw'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      unique case ({enq_fire, deq_fire})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/plab5_mcore_mem_net_req_adapter.sv
// Converts core memory requests into network control/data flits,
// choosing the destination bank and tracking in-flight requests.
module plab5_mcore_mem_net_req_adapter
  import plab5_mcore_mem_net_req_adapter_pkg::*;
#(
  parameter int          p_net_src           = 0,
  parameter int          p_num_banks         = 2,
  parameter int          p_mem_opaque_nbits  = 8,
  parameter int          p_mem_addr_nbits    = 32,
  parameter int          p_mem_data_nbits    = 32,
  parameter int          p_net_opaque_nbits  = 4,
  parameter int          p_net_srcdest_nbits = 3,
  parameter int          p_cacheline_nwords  = 4,
  parameter int          p_single_bank       = 0,
  parameter int          p_dest_mode         = DEST_MODE_REGION,
  parameter logic [31:0] p_inst_boundary     = INST_BOUNDARY_DEFAULT,
  parameter logic [31:0] p_data_boundary     = DATA_BOUNDARY_DEFAULT,
  parameter int          p_queue_depth       = 2,
  parameter int          p_max_outstanding   = 4,
  localparam int mw  = mem_req_nbits(p_mem_opaque_nbits,
                                     p_mem_addr_nbits,
                                     p_mem_data_nbits),
  localparam int npc = mw - p_mem_data_nbits,
  localparam int nw  = net_msg_nbits(npc + 1,
                                     p_net_opaque_nbits,
                                     p_net_srcdest_nbits),
  localparam int ow  = $clog2(p_max_outstanding + 1)
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        domain,
  input  logic                        mem_req_val,
  output logic                        mem_req_rdy,
  input  logic [mw-1:0]               mem_req_msg,
  output logic                        net_val,
  input  logic                        net_rdy,
  output logic [nw-1:0]               net_msg_control,
  output logic [p_mem_data_nbits-1:0] net_msg_data,
  input  logic                        resp_done,
  output logic [ow-1:0]               outstanding
);

  localparam int mo  = p_mem_opaque_nbits;
  localparam int ma  = p_mem_addr_nbits;
  localparam int md  = p_mem_data_nbits;
  localparam int no  = p_net_opaque_nbits;
  localparam int ns  = p_net_srcdest_nbits;
  localparam int ml  = mem_len_nbits(md);
  localparam int lsb = 2 + $clog2(p_cacheline_nwords);
  localparam int bb  = $clog2(p_num_banks);
  localparam int cw  = $clog2(p_queue_depth + 1);

  localparam logic [ns-1:0] src      = ns'(p_net_src);
  localparam logic          src_odd  = p_net_src[0];
  localparam dest_mode_e    dm       = dest_mode_e'(p_dest_mode[0]);
  localparam logic [ma-1:0] inst_bnd = ma'(p_inst_boundary);
  localparam logic [ma-1:0] data_bnd = ma'(p_data_boundary);
  localparam logic [31:0]   max_o    = 32'(p_max_outstanding);

  typedef struct packed {
    logic [MEM_TYPE_NBITS-1:0] kind;
    logic [mo-1:0]             opaque;
    logic [ma-1:0]             addr;
    logic [ml-1:0]             len;
    logic [md-1:0]             data;
  } mem_req_t;

  typedef struct packed {
    logic          mode;
    logic          domain;
    logic [ns-1:0] dest;
    logic [ns-1:0] src;
    logic [no-1:0] opaque;
    logic [npc:0]  payload;
    logic [md-1:0] data;
  } entry_t;

  mem_req_t      req;
  entry_t        enq_entry;
  entry_t        head;
  logic [ns-1:0] dest;
  logic [ma-1:0] bnd;
  logic [no-1:0] seq;
  logic [cw-1:0] count;
  logic [31:0]   inflight;
  logic          cap_ok;
  logic          enq_val;
  logic          enq_rdy;
  logic          enq_fire;
  logic          deq_val;
  logic          deq_fire;
  logic          unused_head;

  assign req = mem_req_msg;
  assign bnd = mode ? data_bnd : inst_bnd;

  always_comb begin
    dest = '0;
    if (p_single_bank == 0) begin
      if (dm == DEST_INTERLEAVE) begin
        dest = ns'(req.addr[lsb +: bb]);
      end else if (req.addr >= bnd) begin
        dest = ns'(1'b1);
      end
    end
  end

  // Source id overwrites the top opaque bits so responses route home.
  always_comb begin
    enq_entry         = '0;
    enq_entry.mode    = mode;
    enq_entry.domain  = domain;
    enq_entry.dest    = dest;
    enq_entry.src     = src;
    enq_entry.opaque  = seq;
    enq_entry.payload = {~src_odd, req.kind,
                         src, req.opaque[mo-ns-1:0],
                         req.addr, req.len};
    enq_entry.data    = req.data;
  end

  // Queued entries count against the in-flight limit before issue.
  assign inflight    = 32'(outstanding) + 32'(count);
  assign cap_ok      = inflight < max_o;
  assign enq_val     = mem_req_val && cap_ok && reset;
  assign mem_req_rdy = reset && enq_rdy && cap_ok;
  assign enq_fire    = mem_req_val && mem_req_rdy;
  assign deq_fire    = deq_val && net_rdy;

  plab5_mcore_ReqQueue #(
    .p_depth (p_queue_depth),
    .p_nbits ($bits(entry_t))
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val),
    .enq_rdy (enq_rdy),
    .enq_msg (enq_entry),
    .deq_val (deq_val),
    .deq_rdy (net_rdy),
    .deq_msg (head),
    .count   (count)
  );

  assign net_val         = deq_val;
  assign net_msg_control = {head.dest, head.src,
                            head.opaque, head.payload};
  assign net_msg_data    = head.data;
  assign unused_head     = ^{head.mode, head.domain};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq <= '0;
    end else if (enq_fire) begin
      seq <= seq + no'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else if (deq_fire && !resp_done) begin
      outstanding <= outstanding + ow'(1);
    end else if (!deq_fire && resp_done && outstanding != '0) begin
      outstanding <= outstanding - ow'(1);
    end
  end

endmodule

// File: doc/plab5_mcore_mem_net_req_adapter.md
PLAB5_MCORE_MEM_NET_REQ_ADAPTER -- requirements
Module: plab5_mcore_mem_net_req_adapter

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- p_net_src, 0, source core id.
- p_num_banks, 2, destination bank count; power of 2, at least 2.
- p_mem_opaque_nbits / p_mem_addr_nbits / p_mem_data_nbits, 8 / 32 / 32, memory message fields (mo / ma / md).
- p_net_opaque_nbits, 4, net opaque width (no).
- p_net_srcdest_nbits, 3, net src/dest width (ns).
- p_cacheline_nwords, 4, words per line.
- p_single_bank, 0, when 1 every destination is 0.
- p_dest_mode, 1, 0 = address interleave, 1 = region compare.
- p_inst_boundary, 32'h4000, instruction region split.
- p_data_boundary, 32'hc000, data region split.
- p_queue_depth, 2, buffer entries; power of 2, at least 2.
- p_max_outstanding, 4, maximum in-flight requests.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset.
- mode, in, 1, 0 = instruction, 1 = data.
- domain, in, 1, security domain of the request.
- mem_req_val, in, 1, request valid.
- mem_req_rdy, out, 1, request ready.
- mem_req_msg, in, VC_MEM_REQ_MSG_NBITS(mo,ma,md), memory request.
- net_val, out, 1, network message valid.
- net_rdy, in, 1, network ready.
- net_msg_control, out, VC_NET_MSG_NBITS(npc+1,no,ns), where npc = mem message width minus md; control flit.
- net_msg_data, out, md, data flit.
- resp_done, in, 1, one pulse per returned response.
- outstanding, out, clog2(p_max_outstanding+1), count of in-flight requests.

REQ-003 SHALL use one clock; reset is asynchronous and active-low, port names clk and reset.

Function
REQ-004 SHALL enqueue a request when mem_req_val and mem_req_rdy are both 1 on a clock edge.
REQ-005 SHALL drive mem_req_rdy = !full && (outstanding + occupancy) < p_max_outstanding.
REQ-006 SHALL at enqueue latch: the converted control fields, the data word, mode, domain, and the computed destination.
REQ-007 SHALL compute the destination as follows:
- p_single_bank = 1: destination is 0.
- p_dest_mode = 0: addr[lsb +: clog2(p_num_banks)], where lsb = 2 + clog2(p_cacheline_nwords).
- p_dest_mode = 1: boundary is p_data_boundary when mode = 1, else p_inst_boundary; addr < boundary gives 0, otherwise 1.
REQ-008 SHALL replace the top ns bits of the memory opaque field with p_net_src[ns-1:0]; the lower mo-ns bits pass through unchanged.
REQ-009 SHALL set the payload control MSB to ~(p_net_src odd).
REQ-010 SHALL set net src = p_net_src[ns-1:0].
REQ-011 SHALL set net opaque to a sequence counter sampled at enqueue; the counter increments per enqueue and wraps modulo 2^no.
REQ-012 SHALL drive net_val = !empty; the head entry is presented combinationally from storage.
REQ-013 SHALL give a minimum latency of 1 cycle: a request accepted at edge t is visible on net_val after edge t; there is no bypass.
REQ-014 SHALL dequeue on net_val && net_rdy.
REQ-015 SHALL hold net_msg_control and net_msg_data stable while net_val && !net_rdy.
REQ-016 SHALL allow enqueue and dequeue in the same cycle when neither full nor empty blocks them; occupancy is then unchanged.
REQ-017 SHALL use circular read/write pointers that wrap at p_queue_depth.
REQ-018 SHALL maintain outstanding as follows:
- +1 on dequeue.
- -1 on resp_done.
- Both in the same cycle: unchanged.
- resp_done at 0: ignored (saturate at 0).
REQ-019 SHALL never let outstanding exceed p_max_outstanding.

Reset
REQ-020 SHALL, while reset = 0, immediately clear pointers, occupancy, sequence counter and outstanding.
REQ-021 SHALL, during reset, hold mem_req_rdy = 0, net_val = 0 and outstanding = 0.
REQ-022 SHALL discard buffered entries on reset asserted mid-operation; no partial message is emitted after release.
REQ-023 SHALL raise mem_req_rdy in the first cycle after reset deasserts.

Structure
REQ-024 SHALL take message field macros and width helpers from the shared plab5-mcore-memreqcmsgpack and vc-net-msgs include files.
REQ-025 SHALL place destination-mode encodings and boundary defaults in the shared plab5_mcore constants package.
REQ-026 SHALL implement the buffer as one sub-module, plab5_mcore_ReqQueue (parametrised depth and width, val/rdy on both sides); destination, opaque and counter logic are in the top.

Verification
REQ-027 SHALL cover: single data read to addr 32'h0000_c010, p_dest_mode = 1, mode = 1 -> one message, dest = 1, opaque = 0, src = p_net_src, latency 1 cycle.
REQ-028 SHALL cover: net_rdy = 0 with 3 requests offered at p_queue_depth = 2 -> 2 accepted, mem_req_rdy = 0; on release, order is preserved and opaque = 0, 1.
REQ-029 SHALL cover: 4 issued with no resp_done at p_max_outstanding = 4 -> mem_req_rdy = 0; a resp_done pulse reopens acceptance for one request.
REQ-030 SHALL cover: p_dest_mode = 0, p_num_banks = 4, addresses 0x00, 0x10, 0x20, 0x30 -> dest = 0, 1, 2, 3.
REQ-031 SHALL cover: 17 enqueues with no = 4 -> opaque wraps 15 -> 0; simultaneous dequeue and resp_done leaves outstanding unchanged.
REQ-032 SHALL cover: reset asserted with 2 entries buffered -> net_val drops asynchronously, outstanding = 0, nothing is emitted after release.
